fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch stage with a 2-entry FIFO.
//
// Fetches instructions from a synchronous ROM (one-cycle read latency) at the
// address held by an external program counter. The unit requests a PC
// increment whenever a fetched word is guaranteed a FIFO slot. It delivers
// instructions with their fetch address through a valid/ready interface.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high reset
//   pc_in        current program-counter value
//   pc_inc       PC increment request (PC advances at the same edge)
//   flush        jump taken; PC is loaded externally at the same edge
//   rom_addr     ROM read address (equals pc_in)
//   rom_data     ROM read data, valid one cycle after the address
//   instr_out    instruction at the FIFO head
//   instr_pc     fetch address of the head instruction
//   instr_valid  head entry valid
//   instr_ready  downstream accepts the head entry
//
// Optional feature (macro FETCH_UNIT_STATS_EN):
//   fetch_count  16-bit count of delivered instructions (pops)
//   stall_count  16-bit count of cycles with valid high and ready low
//   Both wrap, reset to 0 and clear on flush.
module fetch_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_inc,
  input  logic             flush,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
`ifdef FETCH_UNIT_STATS_EN
  ,
  output logic [15:0]      fetch_count,
  output logic [15:0]      stall_count
`endif
);

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] pc_q   [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             inflight_q;
  logic [WIDTH-1:0] inflight_pc_q;

  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       occupancy;

  assign rom_addr    = pc_in;
  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight_q & ~flush;

  // Slots already claimed after this cycle's pop; pop implies count_q >= 1,
  // so the subtraction never underflows.
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Reset gating keeps pc_inc low while the state is held cleared.
  assign issue       = ~reset & ~flush & (occupancy < 3'd2);
  assign pc_inc      = issue;

  assign instr_out   = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q[0]     <= '0;
      data_q[1]     <= '0;
      pc_q[0]       <= '0;
      pc_q[1]       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (flush) begin
      // Drops queued entries and the word returning from the ROM this cycle.
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= rom_data;
        pc_q[wr_ptr_q]   <= inflight_pc_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_in;
      end
    end
  end

`ifdef FETCH_UNIT_STATS_EN
  logic [15:0] fetch_count_q;
  logic [15:0] stall_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else if (flush) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      if (pop) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (instr_valid && !instr_ready) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
